// File: rtl/ahb_lite_sram_subordinate_if.sv
`default_nettype none
// ============================================================================
// Module      : ahb_lite_sram_subordinate_if
// Description : AHB-Lite bus bundle between a manager/interconnect and the
//               SRAM subordinate. The master modport drives the address,
//               control, write data and bus-level HREADY. The slave modport
//               drives HREADYOUT, HRESP and HRDATA.
//               Signals: HSEL, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HPROT,
//               HWDATA, HREADY, HREADYOUT, HRESP, HRDATA.
// Revision    : 1.0 - initial release
// ============================================================================
interface ahb_lite_sram_subordinate_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  HSEL;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic                  HWRITE;
  logic [1:0]            HTRANS;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic                  HREADY;
  logic                  HREADYOUT;
  logic                  HRESP;
  logic [DATA_WIDTH-1:0] HRDATA;

  modport master (
    output HSEL, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HPROT, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HPROT, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface
`default_nettype wire

// File: rtl/ahb_lite_sram_subordinate.sv
`default_nettype none
// ============================================================================
// Module      : ahb_lite_sram_subordinate
// Description : AHB-Lite subordinate backed by a word-organised SRAM array.
//               Supports programmable OKAY wait states, byte/halfword/word
//               writes with little-endian lanes, and two-cycle ERROR
//               responses for illegal size, misalignment or out-of-range
//               addresses.
// Ports       : clk    - bus clock, rising edge
//               HRESET - asynchronous active-high reset
//               bus    - AHB-Lite slave modport (request in, response out)
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_lite_sram_subordinate #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    MEM_DEPTH   = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    WAIT_STATES = 0
) (
  input  logic                          clk,
  input  logic                          HRESET,
  ahb_lite_sram_subordinate_if.slave    bus
);

  localparam int         c_IDX_W = $clog2(MEM_DEPTH);
  localparam logic [3:0] c_WAIT  = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_LAST = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  state_t                  w_accept_state;
  logic [3:0]              r_cnt;
  logic [c_IDX_W-1:0]      r_idx;
  logic [1:0]              r_lane;
  logic [1:0]              r_size;
  logic                    r_write;
  logic [DATA_WIDTH-1:0]   r_mem [MEM_DEPTH];

  logic                    w_hreadyout;
  logic                    w_hresp;
  logic                    w_take;
  logic                    w_err;
  logic                    w_in_range;
  logic                    w_misaligned;
  logic [ADDR_WIDTH-1:0]   w_offset;
  logic                    w_commit;
  logic [3:0]              w_be;
  logic                    w_unused_ok;

  // Burst type, protection and the BUSY/IDLE distinction carry no meaning
  // for a standalone-beat SRAM.
  assign w_unused_ok = ^{bus.HBURST, bus.HPROT, bus.HTRANS[0]};

  // Range check: the array span is a power of two, so every offset bit above
  // the word index must be zero once HADDR is at or above the base.
  assign w_offset     = bus.HADDR - BASE_ADDR;
  assign w_in_range   = (bus.HADDR >= BASE_ADDR) &&
                        (w_offset[ADDR_WIDTH-1:c_IDX_W+2] == '0);
  assign w_misaligned = ((bus.HSIZE == 3'd1) && bus.HADDR[0]) ||
                        ((bus.HSIZE == 3'd2) && (bus.HADDR[1:0] != 2'b00));
  assign w_err        = (bus.HSIZE > 3'd2) || w_misaligned || !w_in_range;

  // An address phase is only taken while this subordinate is ready, so a
  // stray select during our own stall cycles is never captured.
  assign w_take = bus.HSEL && bus.HREADY && bus.HTRANS[1] && w_hreadyout;

  always_ff @(posedge clk or posedge HRESET) begin
    if (HRESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_hreadyout    = 1'b1;
    w_hresp        = 1'b0;
    w_accept_state = w_err ? S_ERR1 : ((c_WAIT != 4'd0) ? S_WAIT : S_LAST);
    case (r_state)
      S_IDLE: begin
        if (bus.HSEL && bus.HREADY && bus.HTRANS[1]) w_state_nxt = w_accept_state;
      end
      S_WAIT: begin
        w_hreadyout = 1'b0;
        if (r_cnt == 4'd1) w_state_nxt = S_LAST;
      end
      S_LAST: begin
        if (bus.HREADY) begin
          w_state_nxt = (bus.HSEL && bus.HTRANS[1]) ? w_accept_state : S_IDLE;
        end
      end
      S_ERR1: begin
        w_hreadyout = 1'b0;
        w_hresp     = 1'b1;
        w_state_nxt = S_ERR2;
      end
      S_ERR2: begin
        w_hresp = 1'b1;
        if (bus.HREADY) begin
          w_state_nxt = (bus.HSEL && bus.HTRANS[1]) ? w_accept_state : S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Captured address/control and the wait-state down-counter.
  always_ff @(posedge clk or posedge HRESET) begin
    if (HRESET) begin
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_lane  <= 2'b00;
      r_size  <= 2'b00;
      r_write <= 1'b0;
    end else begin
      if (w_take) begin
        r_idx   <= w_offset[c_IDX_W+1:2];
        r_lane  <= bus.HADDR[1:0];
        r_size  <= bus.HSIZE[1:0];
        r_write <= bus.HWRITE;
      end
      if (w_take && !w_err) begin
        r_cnt <= c_WAIT;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  // Little-endian byte lanes. Only legal sizes reach LAST, so size 3 is
  // never seen here.
  always_comb begin
    w_be = 4'b0000;
    case (r_size)
      2'd0:    w_be = 4'b0001 << r_lane;
      2'd1:    w_be = r_lane[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  // Writes commit on the edge that closes the final data-phase cycle, which
  // is also the edge that accepts a pipelined follow-on read.
  assign w_commit = (r_state == S_LAST) && r_write && bus.HREADY;

  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[r_idx][8*b +: 8] <= bus.HWDATA[8*b +: 8];
      end
    end
  end

  assign bus.HREADYOUT = w_hreadyout;
  assign bus.HRESP     = w_hresp;
  assign bus.HRDATA    = ((r_state == S_LAST) && !r_write) ? r_mem[r_idx] : '0;

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_sram_subordinate.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ahb_lite_sram_subordinate
// Description : Scoreboard bench for ahb_lite_sram_subordinate. Two DUTs
//               (zero and three wait states) share one driver; a select bit
//               steers HSEL to the DUT under test. Every address phase pushes
//               its expected data-phase response; a monitor pops and checks
//               on each completing data-phase cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_lite_sram_subordinate;

  logic        clk = 1'b0;
  logic        HRESET;
  logic        cur;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;

  always #5 clk = ~clk;

  ahb_lite_sram_subordinate_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
  ahb_lite_sram_subordinate_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus3 ();

  ahb_lite_sram_subordinate #(.WAIT_STATES(0)) dut0 (.clk(clk), .HRESET(HRESET), .bus(bus0));
  ahb_lite_sram_subordinate #(.WAIT_STATES(3)) dut3 (.clk(clk), .HRESET(HRESET), .bus(bus3));

  assign bus0.HSEL   = hsel & ~cur;
  assign bus3.HSEL   = hsel & cur;
  assign bus0.HADDR  = haddr;   assign bus3.HADDR  = haddr;
  assign bus0.HWRITE = hwrite;  assign bus3.HWRITE = hwrite;
  assign bus0.HTRANS = htrans;  assign bus3.HTRANS = htrans;
  assign bus0.HSIZE  = hsize;   assign bus3.HSIZE  = hsize;
  assign bus0.HBURST = hburst;  assign bus3.HBURST = hburst;
  assign bus0.HPROT  = 4'h3;    assign bus3.HPROT  = 4'h3;
  assign bus0.HWDATA = hwdata;  assign bus3.HWDATA = hwdata;
  assign bus0.HREADY = bus0.HREADYOUT;
  assign bus3.HREADY = bus3.HREADYOUT;

  logic        w_ready;
  logic        w_resp;
  logic [31:0] w_rdata;
  assign w_ready = cur ? bus3.HREADYOUT : bus0.HREADYOUT;
  assign w_resp  = cur ? bus3.HRESP     : bus0.HRESP;
  assign w_rdata = cur ? bus3.HRDATA    : bus0.HRDATA;

  typedef struct packed {
    logic        resp;
    logic [31:0] rdata;
    logic [7:0]  nwait;
  } exp_t;

  exp_t  exp_q [$];
  string name_q [$];
  int    n_checks = 0;
  int    n_fail   = 0;
  bit    dp       = 1'b0;
  int    low      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: tracks the data phase that follows every taken address phase.
  initial begin : monitor
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (HRESET) begin
        dp = 1'b0;
        low = 0;
        exp_q.delete();
        name_q.delete();
      end else begin
        if (dp) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard: data phase seen with no expected entry");
            dp = 1'b0;
          end else if (w_ready) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            check({nm, "_resp"},  {31'd0, w_resp}, {31'd0, e.resp});
            check({nm, "_rdata"}, w_rdata, e.rdata);
            check({nm, "_waits"}, low, {24'd0, e.nwait});
            dp = 1'b0;
          end else begin
            low++;
            check({name_q[0], "_stall_resp"}, {31'd0, w_resp}, {31'd0, exp_q[0].resp});
          end
        end
        if (hsel && w_ready) begin
          dp  = 1'b1;
          low = 0;
        end
      end
    end
  end

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!w_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!w_ready) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: HREADYOUT low for %0d cycles, expected high", name, n);
    end
  endtask

  task automatic beat(input logic sel, input logic [1:0] trans, input logic wr,
                      input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic eresp, input logic [31:0] erdata, input int enwait,
                      input string name);
    exp_t e;
    hsel = sel; htrans = trans; hwrite = wr; hsize = size; haddr = addr;
    if (sel) begin
      e.resp = eresp; e.rdata = erdata; e.nwait = 8'(enwait);
      exp_q.push_back(e);
      name_q.push_back(name);
    end
    wait_ready(name);
    @(posedge clk); #1;
    hwdata = wdata;
  endtask

  task automatic wrw(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] d,
                     input int nw, input string name);
    beat(1'b1, 2'd2, 1'b1, size, addr, d, 1'b0, 32'h0, nw, name);
  endtask

  task automatic rdw(input logic [31:0] addr, input logic [31:0] exp, input int nw,
                     input string name);
    beat(1'b1, 2'd2, 1'b0, 3'd2, addr, 32'h0, 1'b0, exp, nw, name);
  endtask

  task automatic drain();
    int n;
    n = 0;
    hsel = 1'b0; htrans = 2'd0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    HRESET = 1'b1; cur = 1'b0; hsel = 1'b0; haddr = '0; hwrite = 1'b0;
    htrans = 2'd0; hsize = 3'd2; hburst = 3'd0; hwdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst0_hreadyout", {31'd0, bus0.HREADYOUT}, 32'd1);
    check("rst0_hresp",     {31'd0, bus0.HRESP},     32'd0);
    check("rst0_hrdata",    bus0.HRDATA,             32'd0);
    check("rst3_hreadyout", {31'd0, bus3.HREADYOUT}, 32'd1);
    check("rst3_hresp",     {31'd0, bus3.HRESP},     32'd0);
    HRESET = 1'b0;
    @(posedge clk); #1;

    // Zero-wait DUT: back-to-back write then read of the same word.
    wrw(32'h10, 3'd2, 32'hDEADBEEF, 0, "w0_wr10");
    rdw(32'h10, 32'hDEADBEEF, 0, "w0_rd10");

    // Byte and halfword lane merges.
    wrw(32'h20, 3'd2, 32'h11223344, 0, "w0_wr20");
    wrw(32'h21, 3'd0, 32'h0000AA00, 0, "w0_wrb21");
    rdw(32'h20, 32'h1122AA44, 0, "w0_rd20_b");
    wrw(32'h22, 3'd1, 32'h55660000, 0, "w0_wrh22");
    rdw(32'h20, 32'h5566AA44, 0, "w0_rd20_h");

    // Boundaries and errors.
    wrw(32'h00,  3'd2, 32'h0BADCAFE, 0, "w0_wr00");
    wrw(32'h3FC, 3'd2, 32'hA5A55A5A, 0, "w0_wrtop");
    rdw(32'h3FC, 32'hA5A55A5A, 0, "w0_rdtop");
    beat(1'b1, 2'd2, 1'b0, 3'd2, 32'h400, 32'h0,        1'b1, 32'h0, 1, "w0_oor_rd");
    beat(1'b1, 2'd2, 1'b1, 3'd2, 32'h02,  32'hFFFFFFFF, 1'b1, 32'h0, 1, "w0_misal_wr");
    beat(1'b1, 2'd2, 1'b1, 3'd1, 32'h21,  32'hFFFFFFFF, 1'b1, 32'h0, 1, "w0_misal_hw");
    beat(1'b1, 2'd2, 1'b0, 3'd3, 32'h00,  32'h0,        1'b1, 32'h0, 1, "w0_bad_size");
    rdw(32'h00, 32'h0BADCAFE, 0, "w0_rd00_keep");
    rdw(32'h20, 32'h5566AA44, 0, "w0_rd20_keep");

    // INCR4 write burst with a BUSY beat, then readback.
    hburst = 3'b011;
    beat(1'b1, 2'd2, 1'b1, 3'd2, 32'h40, 32'd1, 1'b0, 32'h0, 0, "w0_bst0");
    beat(1'b1, 2'd3, 1'b1, 3'd2, 32'h44, 32'd2, 1'b0, 32'h0, 0, "w0_bst1");
    beat(1'b1, 2'd1, 1'b1, 3'd2, 32'h48, 32'h0, 1'b0, 32'h0, 0, "w0_busy");
    beat(1'b1, 2'd3, 1'b1, 3'd2, 32'h48, 32'd3, 1'b0, 32'h0, 0, "w0_bst2");
    beat(1'b1, 2'd3, 1'b1, 3'd2, 32'h4C, 32'd4, 1'b0, 32'h0, 0, "w0_bst3");
    hburst = 3'b000;
    beat(1'b1, 2'd0, 1'b0, 3'd2, 32'h10, 32'h0, 1'b0, 32'h0, 0, "w0_idle_sel");
    for (int i = 0; i < 4; i++) begin
      rdw(32'h40 + 32'(4*i), 32'(i + 1), 0, $sformatf("w0_rdb%0d", i));
    end
    drain();

    // Three-wait-state DUT.
    cur = 1'b1;
    @(posedge clk); #1;
    wrw(32'h80, 3'd2, 32'h12345678, 3, "w3_wr80");
    rdw(32'h80, 32'h12345678, 3, "w3_rd80a");
    rdw(32'h80, 32'h12345678, 3, "w3_rd80b");
    beat(1'b1, 2'd2, 1'b0, 3'd1, 32'h81, 32'h0, 1'b1, 32'h0, 1, "w3_misal_rd");
    drain();

    // Reset in the middle of a write's wait states.
    begin
      exp_t e;
      hsel = 1'b1; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h80;
      e.resp = 1'b0; e.rdata = 32'h0; e.nwait = 8'd3;
      exp_q.push_back(e);
      name_q.push_back("w3_rst_wr");
      wait_ready("w3_rst_wr");
      @(posedge clk); #1;
      hwdata = 32'hCAFEF00D; hsel = 1'b0; htrans = 2'd0;
      @(negedge clk);
      check("w3_rst_inwait", {31'd0, w_ready}, 32'd0);
      #2 HRESET = 1'b1;
      #1;
      check("w3_rst_hreadyout", {31'd0, w_ready}, 32'd1);
      check("w3_rst_hresp",     {31'd0, w_resp},  32'd0);
      check("w3_rst_hrdata",    w_rdata,          32'd0);
      @(posedge clk);
      @(posedge clk); #1;
      HRESET = 1'b0;
    end
    rdw(32'h80, 32'h12345678, 3, "w3_rd80_keep");
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
